// File: rtl/noekeon_stream_driver.sv
`default_nettype none
// ============================================================================
// Module   : noekeon_stream_driver
// Brief    : Packs 32-bit stream words into 128-bit key/data blocks, drives the
//            Noekeon core strobes and streams the 128-bit result back out.
//            Optional macro NOEKEON_DRV_TIMEOUT_EN adds a WAIT_HI watchdog.
// Revision : 1.0  initial release
// ============================================================================
module noekeon_stream_driver #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         inClk,
    input  logic         inReset,
    input  logic         inCfgMode,
    input  logic         inCfgDecipher,
    input  logic         inWordValid,
    input  logic         inWordIsKey,
    input  logic [31:0]  inWordData,
    output logic         outWordReady,
    output logic         outResValid,
    output logic [31:0]  outResData,
    output logic         outResLast,
    input  logic         inResReady,
    output logic         outCoreMode,
    output logic         outCoreDecipher,
    output logic         outCoreKeyWr,
    output logic         outCoreDataWr,
    output logic [127:0] outCoreBlock,
    input  logic         inCoreBusy,
    input  logic [127:0] inCoreData,
    output logic         outDrvBusy,
    output logic         outErr
);

    typedef enum logic [2:0] {
        S_COLLECT    = 3'd0,
        S_KEY_ISSUE  = 3'd1,
        S_DATA_ISSUE = 3'd2,
        S_WAIT_HI    = 3'd3,
        S_WAIT_LO    = 3'd4,
        S_CAPTURE    = 3'd5,
        S_SEND       = 3'd6
    } state_t;

    state_t         r_state;
    logic [1:0]     r_word_cnt;
    logic           r_is_key;
    logic [127:0]   r_block;
    logic [127:0]   r_result;
    logic [1:0]     r_res_idx;
    logic           r_word_ready;
    logic           r_res_valid;
    logic           r_mode;
    logic           r_decipher;
    logic           r_key_wr;
    logic           r_data_wr;
    logic           r_err;

    logic           w_word_xfer;
    logic           w_res_xfer;
    logic           w_type_clash;
    logic [1:0]     w_slot;
    logic           w_tmo_hit;

    assign w_word_xfer  = r_word_ready & inWordValid;
    assign w_res_xfer   = r_res_valid & inResReady;
    // A type change restarts the group: the clashing word lands in slot 0.
    assign w_type_clash = (r_word_cnt != 2'd0) && (inWordIsKey != r_is_key);
    assign w_slot       = w_type_clash ? 2'd0 : r_word_cnt;

`ifdef NOEKEON_DRV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge inClk or negedge inReset) begin
        if (!inReset) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_WAIT_HI) begin
            r_tmo_cnt <= '0;
        end else if (!w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo_param;
    assign w_unused_tmo_param = (TIMEOUT_CYCLES == 0);
    assign w_tmo_hit          = 1'b0;
`endif

    always_ff @(posedge inClk or negedge inReset) begin
        if (!inReset) begin
            r_state      <= S_COLLECT;
            r_word_cnt   <= 2'd0;
            r_is_key     <= 1'b0;
            r_block      <= '0;
            r_result     <= '0;
            r_res_idx    <= 2'd0;
            r_word_ready <= 1'b0;
            r_res_valid  <= 1'b0;
            r_mode       <= 1'b0;
            r_decipher   <= 1'b0;
            r_key_wr     <= 1'b0;
            r_data_wr    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_key_wr  <= 1'b0;
            r_data_wr <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    r_mode       <= inCfgMode;
                    r_decipher   <= inCfgDecipher;
                    r_word_ready <= 1'b1;
                    if (w_word_xfer) begin
                        if (w_type_clash) begin
                            r_err <= 1'b1;
                        end
                        if (w_slot == 2'd0) begin
                            r_is_key <= inWordIsKey;
                        end
                        case (w_slot)
                            2'd0:    r_block[127:96] <= inWordData;
                            2'd1:    r_block[95:64]  <= inWordData;
                            2'd2:    r_block[63:32]  <= inWordData;
                            default: r_block[31:0]   <= inWordData;
                        endcase
                        r_word_cnt <= w_slot + 2'd1;
                        if (w_slot == 2'd3) begin
                            r_word_ready <= 1'b0;
                            r_state      <= r_is_key ? S_KEY_ISSUE : S_DATA_ISSUE;
                        end
                    end
                end
                S_KEY_ISSUE: begin
                    if (!inCoreBusy) begin
                        r_key_wr <= 1'b1;
                        // Direct-mode key load gives no busy handshake.
                        if (!r_mode) begin
                            r_state      <= S_COLLECT;
                            r_word_ready <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_HI;
                        end
                    end
                end
                S_DATA_ISSUE: begin
                    if (!inCoreBusy) begin
                        r_data_wr <= 1'b1;
                        r_state   <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (inCoreBusy) begin
                        r_state <= S_WAIT_LO;
                    end else if (w_tmo_hit) begin
                        r_err        <= 1'b1;
                        r_state      <= S_COLLECT;
                        r_word_ready <= 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!inCoreBusy) begin
                        if (r_is_key) begin
                            r_state      <= S_COLLECT;
                            r_word_ready <= 1'b1;
                        end else begin
                            r_state <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_result    <= inCoreData;
                    r_res_idx   <= 2'd0;
                    r_res_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_res_xfer) begin
                        if (r_res_idx == 2'd3) begin
                            r_res_valid  <= 1'b0;
                            r_res_idx    <= 2'd0;
                            r_word_cnt   <= 2'd0;
                            r_word_ready <= 1'b1;
                            r_state      <= S_COLLECT;
                        end else begin
                            r_res_idx <= r_res_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    always_comb begin
        outResData = r_result[127:96];
        case (r_res_idx)
            2'd1:    outResData = r_result[95:64];
            2'd2:    outResData = r_result[63:32];
            2'd3:    outResData = r_result[31:0];
            default: outResData = r_result[127:96];
        endcase
    end

    assign outWordReady    = r_word_ready;
    assign outResValid     = r_res_valid;
    assign outResLast      = r_res_valid & (r_res_idx == 2'd3);
    assign outCoreMode     = r_mode;
    assign outCoreDecipher = r_decipher;
    assign outCoreKeyWr    = r_key_wr;
    assign outCoreDataWr   = r_data_wr;
    assign outCoreBlock    = r_block;
    assign outDrvBusy      = (r_state != S_COLLECT);
    assign outErr          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noekeon_stream_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_noekeon_stream_driver
// Brief    : Directed bench with a behavioural core stub and a result scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_noekeon_stream_driver;

    logic         clk;
    logic         rst_n;
    logic         cfg_mode;
    logic         cfg_dec;
    logic         w_valid;
    logic         w_is_key;
    logic [31:0]  w_data;
    logic         res_ready;
    logic         man_busy;
    logic         stub_busy;
    logic         stub_auto;
    logic         stub_arm;
    int           stub_left;
    int           busy_len;
    logic [127:0] core_data;
    logic         core_busy;

    logic         o_word_ready;
    logic         o_res_valid;
    logic [31:0]  o_res_data;
    logic         o_res_last;
    logic         o_core_mode;
    logic         o_core_dec;
    logic         o_key_wr;
    logic         o_data_wr;
    logic [127:0] o_block;
    logic         o_drv_busy;
    logic         o_err;

    int           n_vec;
    int           n_err;
    logic [32:0]  exp_q[$];

    assign core_busy = stub_auto ? stub_busy : man_busy;

    noekeon_stream_driver #(.TIMEOUT_CYCLES(8)) dut (
        .inClk           (clk),
        .inReset         (rst_n),
        .inCfgMode       (cfg_mode),
        .inCfgDecipher   (cfg_dec),
        .inWordValid     (w_valid),
        .inWordIsKey     (w_is_key),
        .inWordData      (w_data),
        .outWordReady    (o_word_ready),
        .outResValid     (o_res_valid),
        .outResData      (o_res_data),
        .outResLast      (o_res_last),
        .inResReady      (res_ready),
        .outCoreMode     (o_core_mode),
        .outCoreDecipher (o_core_dec),
        .outCoreKeyWr    (o_key_wr),
        .outCoreDataWr   (o_data_wr),
        .outCoreBlock    (o_block),
        .inCoreBusy      (core_busy),
        .inCoreData      (core_data),
        .outDrvBusy      (o_drv_busy),
        .outErr          (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: a strobe that expects a handshake raises busy for busy_len cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            stub_busy = 1'b0;
            stub_left = 0;
        end else if (stub_left > 0) begin
            stub_left = stub_left - 1;
            if (stub_left == 0) stub_busy = 1'b0;
        end else if (stub_arm && (o_data_wr || (o_key_wr && o_core_mode))) begin
            stub_busy = 1'b1;
            stub_left = busy_len;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_word(input logic is_key, input logic [31:0] d);
        int n;
        n = 0;
        w_valid  = 1'b1;
        w_is_key = is_key;
        w_data   = d;
        while (!o_word_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("word_ready", o_word_ready, 1'b1);
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic send_block(input logic is_key, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) send_word(is_key, blk[127-32*i -: 32]);
    endtask

    task automatic push_result(input logic [127:0] r);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), r[127-32*i -: 32]});
    endtask

    task automatic recv_result(input logic [3:0] pattern);
        int xfers;
        int n;
        logic [32:0] e;
        xfers = 0;
        n = 0;
        while (xfers < 4 && n < 200) begin
            res_ready = pattern[n % 4];
            if (o_res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_extra", o_res_valid, 1'b0);
                end else begin
                    e = exp_q[0];
                    check("res_data", o_res_data, e[31:0]);
                    check("res_last", o_res_last, e[32]);
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
            end
            @(negedge clk);
            n++;
        end
        res_ready = 1'b0;
        check("res_xfers", xfers, 4);
        check("res_valid_after", o_res_valid, 1'b0);
    endtask

    initial begin
        logic [127:0] blk;
        logic [127:0] res;
        int seen;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        cfg_mode = 1'b1;
        cfg_dec = 1'b1;
        w_valid = 1'b0;
        w_is_key = 1'b0;
        w_data = '0;
        res_ready = 1'b0;
        man_busy = 1'b0;
        stub_auto = 1'b1;
        stub_arm = 1'b1;
        busy_len = 5;
        core_data = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_outputs",
              {o_word_ready, o_res_valid, o_res_data, o_res_last, o_core_mode, o_core_dec,
               o_key_wr, o_data_wr, o_drv_busy, o_err}, '0);
        check("rst_block", o_block, '0);
        rst_n = 1'b1;
        #1 check("ready_at_release", o_word_ready, 1'b0);
        @(negedge clk);
        check("ready_after_edge", o_word_ready, 1'b1);
        check("mode_registered", o_core_mode, 1'b1);
        cfg_mode = 1'b0;
        cfg_dec = 1'b0;
        @(negedge clk);

        // Direct key load of zeros, then zero data block
        send_block(1'b1, '0);
        @(negedge clk);
        check("kwr_pulse", o_key_wr, 1'b1);
        check("direct_key_done", o_drv_busy, 1'b0);
        @(negedge clk);
        check("kwr_one_cycle", o_key_wr, 1'b0);
        core_data = 128'hb1656851_699e29fa_24b70148_503d2dfc;
        push_result(core_data);
        send_block(1'b0, '0);
        recv_result(4'b1111);

        // Busy held before issue, manual busy sequence, stalled sink
        stub_auto = 1'b0;
        man_busy = 1'b1;
        blk = 128'h01234567_89abcdef_fedcba98_76543210;
        res = 128'h11112222_33334444_55556666_77778888;
        core_data = res;
        push_result(res);
        send_block(1'b0, blk);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_data_wr) seen++;
        end
        check("dwr_while_busy", seen, 0);
        man_busy = 1'b0;
        @(negedge clk);
        check("dwr_pulse", o_data_wr, 1'b1);
        check("block_at_issue", o_block, blk);
        man_busy = 1'b1;
        @(negedge clk);
        check("dwr_one_cycle", o_data_wr, 1'b0);
        seen = 0;
        repeat (11) begin
            @(negedge clk);
            if (o_res_valid) seen++;
        end
        check("valid_during_busy", seen, 0);
        man_busy = 1'b0;
        @(negedge clk);
        check("valid_capture_cycle", o_res_valid, 1'b0);
        @(negedge clk);
        check("valid_latency", o_res_valid, 1'b1);
        recv_result(4'b1001);
        stub_auto = 1'b1;

        // Type clash restarts the group as data
        do_reset();
        core_data = 128'hdeadbeef_cafef00d_0badc0de_feedface;
        send_word(1'b1, 32'h0);
        send_word(1'b1, 32'h1);
        check("err_before_clash", o_err, 1'b0);
        send_word(1'b0, 32'haaaa0001);
        check("err_on_clash", o_err, 1'b1);
        push_result(core_data);
        send_word(1'b0, 32'hbbbb0002);
        send_word(1'b0, 32'hcccc0003);
        send_word(1'b0, 32'hdddd0004);
        check("clash_block", o_block, 128'haaaa0001_bbbb0002_cccc0003_dddd0004);
        recv_result(4'b1111);
        check("err_sticky", o_err, 1'b1);

        // Reset while a result is pending in SEND
        do_reset();
        core_data = 128'h0f0f0f0f_1e1e1e1e_2d2d2d2d_3c3c3c3c;
        send_block(1'b0, 128'h5);
        seen = 0;
        while (!o_res_valid && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        check("send_reached", o_res_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", o_res_valid, 1'b0);
        check("rst_async_state", o_drv_busy, 1'b0);
        check("rst_async_ready", o_word_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef NOEKEON_DRV_TIMEOUT_EN
        // Busy never rises: watchdog fires after 8 WAIT_HI cycles
        do_reset();
        stub_arm = 1'b0;
        send_block(1'b0, 128'h77);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_res_valid) seen++;
        end
        check("tmo_err_early", o_err, 1'b0);
        check("tmo_busy_early", o_drv_busy, 1'b1);
        @(negedge clk);
        check("tmo_err", o_err, 1'b1);
        check("tmo_collect", o_drv_busy, 1'b0);
        repeat (10) begin
            @(negedge clk);
            if (o_res_valid) seen++;
        end
        check("tmo_no_result", seen, 0);
        stub_arm = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noekeon_stream_driver.md
Name: noekeon_stream_driver

Overview:
- Host-side initiator for the Noekeon core. Accepts 32-bit words over a valid/ready stream and assembles them into 128-bit key or data blocks.
- Issues the core's key-write and data-write strobes, tracks the core busy handshake, and captures the 128-bit result.
- Returns the result as four 32-bit words on a valid/ready output stream.
- Sits between the system bus or DMA and the Noekeon top level; drives its inMode, inDecipher, inKeyWr/inKeyData and inDataWr/inDataData, and observes its outBusy/outData.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles to wait for core busy to rise after a strobe. Used only with NOEKEON_DRV_TIMEOUT_EN.

Ports:
- inClk  in  1  clock
- inReset  in  1  asynchronous active-low reset
- inCfgMode  in  1  key mode for the core: 0 direct, 1 indirect
- inCfgDecipher  in  1  0 encipher, 1 decipher
- inWordValid  in  1  input word valid
- inWordIsKey  in  1  1: word belongs to a key block; 0: word belongs to a data block
- inWordData  in  32  input word
- outWordReady  out  1  driver accepts a word
- outResValid  out  1  result word valid
- outResData  out  32  result word
- outResLast  out  1  marks the 4th result word
- inResReady  in  1  sink accepts a result word
- outCoreMode  out  1  to core inMode
- outCoreDecipher  out  1  to core inDecipher
- outCoreKeyWr  out  1  to core inKeyWr
- outCoreDataWr  out  1  to core inDataWr
- outCoreBlock  out  128  to core inKeyData and inDataData
- inCoreBusy  in  1  from core outBusy
- inCoreData  in  128  from core outData
- outDrvBusy  out  1  FSM not in COLLECT
- outErr  out  1  sticky error flag; cleared by reset only

Behaviour:
- Reset (inReset=0, asynchronous): FSM=COLLECT, word count=0, block register=0, every output 0.
- Exception: outWordReady becomes 1 on the first edge after reset release.
- FSM states: COLLECT, KEY_ISSUE, DATA_ISSUE, WAIT_HI, WAIT_LO, CAPTURE, SEND.
- COLLECT:
  - outWordReady=1; a transfer occurs when valid&ready on a rising edge.
  - Word k (0..3) is written to block bits [127-32k -: 32]; the first word is the MSW.
  - outCoreMode and outCoreDecipher are registered from the inCfg* inputs every COLLECT cycle and held constant in all other states.
  - The group's type is latched from inWordIsKey at word 0.
  - A word whose inWordIsKey differs from the latched type sets outErr. That word becomes word 0 of a new group of its own type; earlier partial words are discarded.
  - On the 4th accepted word: go to KEY_ISSUE or DATA_ISSUE. outWordReady is 0 from the next cycle.
- KEY_ISSUE / DATA_ISSUE:
  - Stay while inCoreBusy=1.
  - On an edge with inCoreBusy=0: the matching strobe (outCoreKeyWr or outCoreDataWr, registered) is 1 for exactly one cycle. outCoreBlock is stable from the issue state until the FSM returns to COLLECT.
  - Key in direct mode (outCoreMode=0): return to COLLECT after the strobe cycle.
  - Key in indirect mode, or any data block: go to WAIT_HI.
- WAIT_HI: wait for inCoreBusy=1, then go to WAIT_LO. A strobe may never be issued while busy=1.
- WAIT_LO:
  - On inCoreBusy=0 after a key operation: go to COLLECT.
  - On inCoreBusy=0 after a data operation: go to CAPTURE.
- CAPTURE: one cycle. The result register samples inCoreData, then the FSM goes to SEND.
- SEND:
  - outResValid=1; outResData = result word r (MSW first); outResLast=1 when r=3.
  - r advances only on valid&ready. outResData is held stable while inResReady=0.
  - After word 3 is accepted: go to COLLECT, clear counts.
- Latency, data path:
  - 4th input word accepted at edge N → outCoreDataWr high in cycle N+1 (core idle).
  - Core busy falls at edge M → CAPTURE in cycle M+1 → first outResValid at M+2.
- Back-to-back blocks: the next group cannot start until SEND finishes. There is no overlap; throughput is one block per (core latency + ~10) cycles.
- Reset mid-operation: all state aborts immediately. A strobe in progress is deasserted asynchronously. The partial result is discarded.

Optional Feature:
- Macro: NOEKEON_DRV_TIMEOUT_EN.
- Defined: a counter runs in WAIT_HI. If inCoreBusy has not risen after TIMEOUT_CYCLES cycles, outErr is set and the FSM goes to COLLECT. No result is sent; the counter clears on every WAIT_HI entry.
- Undefined: WAIT_HI waits indefinitely and there is no counter logic.

Test Plan:
- Reset → all outputs 0; outWordReady=1 one cycle after reset release; assert reset during SEND → outResValid drops asynchronously, FSM=COLLECT.
- Direct key 4×0x00000000, then data 4×0x00000000, inCfgDecipher=0, real core → result words b1656851, 699e29fa, 24b70148, 503d2dfc; outResLast only on the 4th word.
- Core stub with busy held 12 cycles and a preset result → outCoreDataWr is exactly one cycle, issued only when busy=0; first outResValid two cycles after busy falls.
- inResReady toggled 1,0,0,1… → each word is held stable while stalled; exactly 4 transfers occur, in order.
- Key-flagged words 0,1, then a data-flagged word → outErr=1; that data word becomes word 0 and the next 3 data words complete a data block.
- With NOEKEON_DRV_TIMEOUT_EN and TIMEOUT_CYCLES=8, stub never raises busy → outErr=1 after 8 cycles in WAIT_HI; FSM=COLLECT; outResValid never asserts.
